gate_reduce_unit: RTL and testbench

Parametrised, clocked successor to the two-input AND gate: folds a stream of WIDTH-bit operand beats with a selectable bitwise operator (AND/OR/XOR/NAND) and returns one registered result per packet. Input and output use valid/ready handshakes, so the block drops into any streaming datapath that needs a bitwise reduction over a variable-length packet.

---
 rtl/gate_pkg.sv | 29 ++
 rtl/gate_alu.sv | 22 ++
 rtl/gate_reduce_unit.sv | 110 +++++++++++
 tb/tb_gate_reduce_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared types and the per-bit fold operator for the gate reduction datapath.
// Combinational helpers only; no latency or flow control lives here.
// NAND folds as AND; the inversion is applied once when the result is emitted.
package gate_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } gate_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } gr_state_t;

  function automatic logic gate_fold(input logic a, input logic b, input gate_op_t op);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_alu.sv
// Bitwise fold of two operands with the selected gate operator.
// Purely combinational, zero latency.
// No flow control; the caller qualifies when the result is used.
module gate_alu
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gate_op_t         op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < WIDTH; i++) begin
      y[i] = gate_fold(a[i], b[i], op);
    end
  end

endmodule

// File: rtl/gate_reduce_unit.sv
// Folds a packet of operand beats with AND/OR/XOR/NAND into one registered result.
// Latency: out_valid rises the cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result waits; the result holds until out_ready.
module gate_reduce_unit
  import gate_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);

  gr_state_t        state_q, state_d;
  gate_op_t         op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d, fold_y;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             load_out;

  gate_alu #(.WIDTH(WIDTH)) u_fold (
    .a  (acc_q),
    .b  (in_data),
    .op (op_q),
    .y  (fold_y)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    load_out  = 1'b0;
    in_ready  = 1'b0;
    out_valid = (state_q == OUT);
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          acc_d = in_data;
          op_d  = gate_op_t'(op_i);
          cnt_d = CW'(1);
          ovf_d = 1'b0;
          if (in_last) begin
            state_d  = OUT;
            load_out = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          acc_d = fold_y;
          // Count saturates; a beat arriving at the cap marks the packet overflowed.
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
          ovf_d = ovf_q | (cnt_q == CNT_MAX);
          if (in_last) begin
            state_d  = OUT;
            load_out = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_AND;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (load_out) begin
        out_data     <= (op_d == OP_NAND) ? ~acc_d : acc_d;
        out_count    <= cnt_d;
        out_overflow <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Directed and randomised checks of gate_reduce_unit against hand-computed values and a packet model.
module tb_gate_reduce_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] op_i;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] out_count;
  logic       out_overflow;

  int checks = 0;
  int errors = 0;

  gate_reduce_unit #(.WIDTH(8), .MAX_BEATS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_i         (op_i),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] d, input logic [1:0] op, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    op_i     = op;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("beat_timeout", guard < 100, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(input int hold, output logic [7:0] d, output logic [4:0] c,
                            output logic v);
    int guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("result_timeout", guard < 200, 1);
    repeat (hold) @(negedge clk);
    d = out_data;
    c = out_count;
    v = out_overflow;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_after_take", in_ready, 1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [4:0] rc;
    logic       rv;
    logic [7:0] exp_d;
    logic [1:0] pop;
    int         n;

    rst_n = 1'b0; op_i = 2'd0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_overflow", out_overflow, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single AND beat: result appears the cycle after acceptance.
    send_beat(8'hA5, 2'd0, 1'b1);
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_in_ready_low", in_ready, 0);
    get_result(0, rd, rc, rv);
    chk("t1_data", rd, 8'hA5);
    chk("t1_count", rc, 1);
    chk("t1_ovf", rv, 0);

    // XOR over three beats, held for four cycles of backpressure.
    send_beat(8'h0F, 2'd2, 1'b0);
    send_beat(8'hF0, 2'd2, 1'b0);
    send_beat(8'hFF, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 8'h00);
      chk("t2_hold_count", out_count, 3);
      chk("t2_hold_in_ready", in_ready, 0);
    end
    get_result(0, rd, rc, rv);
    chk("t2_data", rd, 8'h00);
    chk("t2_count", rc, 3);

    // NAND with a mid-packet op change that must be ignored.
    send_beat(8'hFF, 2'd3, 1'b0);
    send_beat(8'h3C, 2'd1, 1'b1);
    get_result(1, rd, rc, rv);
    chk("t3_data", rd, 8'hC3);
    chk("t3_count", rc, 2);

    // 18 OR beats: count saturates, overflow set.
    for (int i = 0; i < 18; i++) send_beat(8'h01, 2'd1, i == 17);
    get_result(0, rd, rc, rv);
    chk("t4_data", rd, 8'h01);
    chk("t4_count", rc, 16);
    chk("t4_ovf", rv, 1);
    send_beat(8'h55, 2'd2, 1'b0);
    send_beat(8'h0F, 2'd2, 1'b1);
    get_result(0, rd, rc, rv);
    chk("t4b_data", rd, 8'h5A);
    chk("t4b_count", rc, 2);
    chk("t4b_ovf", rv, 0);

    // Reset mid-packet discards the partial packet.
    send_beat(8'h11, 2'd0, 1'b0);
    send_beat(8'h22, 2'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_result", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_beat(8'hF0, 2'd0, 1'b0);
    send_beat(8'h3C, 2'd0, 1'b1);
    get_result(0, rd, rc, rv);
    chk("t5_data", rd, 8'h30);
    chk("t5_count", rc, 2);
    chk("t5_ovf", rv, 0);

    // Randomised packets with input gaps and output stalls against a model.
    for (int p = 0; p < 200; p++) begin
      pop = 2'($urandom_range(0, 3));
      n   = $urandom_range(1, 20);
      exp_d = 8'h00;
      for (int b = 0; b < n; b++) begin
        logic [7:0] d;
        d = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        if (b == 0) exp_d = d;
        else if (pop == 2'd1) exp_d = exp_d | d;
        else if (pop == 2'd2) exp_d = exp_d ^ d;
        else exp_d = exp_d & d;
        send_beat(d, (b == 0) ? pop : 2'($urandom_range(0, 3)), b == n - 1);
      end
      if (pop == 2'd3) exp_d = ~exp_d;
      get_result($urandom_range(0, 3), rd, rc, rv);
      chk("rnd_data", rd, exp_d);
      chk("rnd_count", rc, (n > 16) ? 16 : n);
      chk("rnd_ovf", rv, n > 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
